// File: rtl/noise_burst_ctrl_pkg.sv
// Shared types and constants for the noise burst envelope sequencer.
// Default build has no loop port; define NOISE_BURST_LOOP_EN in the top for burst looping.
package noise_ctrl_pkg;

   localparam int DW_DEF    = 16;
   localparam int ENV_W_DEF = 8;
   localparam int CNT_W_DEF = 16;

   // Envelope phase; the encoding is visible on state_o.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ATTACK  = 2'd1,
      ST_SUSTAIN = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Largest unsigned gain representable in env_w bits.
   function automatic int gain_max(input int env_w);
      return (1 << env_w) - 1;
   endfunction

endpackage

// File: rtl/noise_burst_ctrl_gain_mul.sv
// Signed noise word times unsigned gain, scaled back by 2^ENV_W and truncated to DW.
// Purely combinational so it can be reused in per-voice gain stages.
module noise_gain_mul #(
   parameter int DW    = 16,
   parameter int ENV_W = 8
) (
   input  logic [DW-1:0]    noise_i,
   input  logic [ENV_W-1:0] gain_i,
   output logic [DW-1:0]    prod_o
);

   logic signed [DW+ENV_W:0] prod_full;
   logic                     unused_prod_bits;

   // Gain is zero-extended so the multiply stays signed without flipping large gains negative.
   always_comb begin
      prod_full = $signed(noise_i) * $signed({1'b0, gain_i});
   end

   assign prod_o           = prod_full[DW+ENV_W-1:ENV_W];
   assign unused_prod_bits = ^{prod_full[ENV_W-1:0], prod_full[DW+ENV_W]};

endmodule

// File: rtl/noise_burst_ctrl.sv
// Envelope sequencer for the LFSR noise source: trig starts an attack/sustain/release
// burst paced by sample_tick; each accepted tick scales the noise word by the envelope
// gain and presents it on a valid/ready output.
// Optional macro NOISE_BURST_LOOP_EN adds a 'loop' input that restarts the attack when
// the release reaches zero gain.
module noise_burst_ctrl
   import noise_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int ENV_W = ENV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic             trig,
   input  logic             abort,
`ifdef NOISE_BURST_LOOP_EN
   input  logic             loop,
`endif
   input  logic [ENV_W-1:0] attack_step,
   input  logic [ENV_W-1:0] release_step,
   input  logic [CNT_W-1:0] sustain_len,
   input  logic [DW-1:0]    noise_in,
   output logic             noise_step,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [1:0]       state_o,
   output logic             overrun
);

   localparam logic [ENV_W-1:0] GAIN_MAX = ENV_W'(gain_max(ENV_W));

   state_t           state_q;
   logic [ENV_W-1:0] gain_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ENV_W-1:0] attack_step_q;
   logic [ENV_W-1:0] release_step_q;
   logic [CNT_W-1:0] sustain_len_q;
   logic [DW-1:0]    out_data_q;
   logic             out_valid_q;
   logic             overrun_q;

   logic             slot_free;
   logic             tick_live;
   logic             sample_ev;
   logic             tick_drop;
   logic             trig_ok;
   logic [ENV_W:0]   attack_sum;
   logic             attack_sat;
   logic             release_empty;
   logic [DW-1:0]    scaled;

   // Scale with the gain held before this tick's envelope update.
   noise_gain_mul #(
      .DW    (DW),
      .ENV_W (ENV_W)
   ) u_gain_mul (
      .noise_i (noise_in),
      .gain_i  (gain_q),
      .prod_o  (scaled)
   );

   // Tick qualification and envelope arithmetic; abort suppresses any tick in its cycle.
   always_comb begin
      slot_free     = !out_valid_q || out_ready;
      tick_live     = sample_tick && (state_q != ST_IDLE) && !abort;
      sample_ev     = tick_live && slot_free;
      tick_drop     = tick_live && !slot_free;
      trig_ok       = trig && !abort && ((state_q == ST_IDLE) || (state_q == ST_RELEASE));
      attack_sum    = {1'b0, gain_q} + {1'b0, attack_step_q};
      attack_sat    = (attack_step_q == '0) || (attack_sum >= {1'b0, GAIN_MAX});
      release_empty = (release_step_q == '0) || (gain_q <= release_step_q);
   end

   // Envelope FSM, config latch and registered output slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         gain_q         <= '0;
         cnt_q          <= '0;
         attack_step_q  <= '0;
         release_step_q <= '0;
         sustain_len_q  <= '0;
         out_data_q     <= '0;
         out_valid_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         if (sample_ev) begin
            out_data_q  <= scaled;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (tick_drop) begin
            overrun_q <= 1'b1;
         end

         if (abort) begin
            state_q <= ST_IDLE;
            gain_q  <= '0;
         end else if (trig_ok) begin
            attack_step_q  <= attack_step;
            release_step_q <= release_step;
            sustain_len_q  <= sustain_len;
            if (state_q == ST_IDLE) begin
               gain_q <= '0;
            end
            state_q <= ST_ATTACK;
         end else if (sample_ev) begin
            case (state_q)
               ST_ATTACK: begin
                  if (attack_sat) begin
                     gain_q  <= GAIN_MAX;
                     cnt_q   <= sustain_len_q;
                     state_q <= ST_SUSTAIN;
                  end else begin
                     gain_q <= attack_sum[ENV_W-1:0];
                  end
               end
               ST_SUSTAIN: begin
                  if (cnt_q == '0) begin
                     state_q <= ST_RELEASE;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_RELEASE: begin
                  if (release_empty) begin
                     gain_q <= '0;
`ifdef NOISE_BURST_LOOP_EN
                     state_q <= loop ? ST_ATTACK : ST_IDLE;
`else
                     state_q <= ST_IDLE;
`endif
                  end else begin
                     gain_q <= gain_q - release_step_q;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign noise_step = sample_ev;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);
   assign state_o    = state_q;

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// Self-checking bench for noise_burst_ctrl: directed scenarios followed by random traffic,
// all compared against an integer envelope model kept in this file.
module tb_noise_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic        trig;
   logic        abort;
   logic [7:0]  attack_step;
   logic [7:0]  release_step;
   logic [15:0] sustain_len;
   logic [15:0] noise_in;
   logic        noise_step;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [1:0]  state_o;
   logic        overrun;

   always #5 clk = ~clk;

   noise_burst_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .trig         (trig),
      .abort        (abort),
`ifdef NOISE_BURST_LOOP_EN
      .loop         (1'b0),
`endif
      .attack_step  (attack_step),
      .release_step (release_step),
      .sustain_len  (sustain_len),
      .noise_in     (noise_in),
      .noise_step   (noise_step),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .state_o      (state_o),
      .overrun      (overrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: phase 0..3, gain as a plain integer 0..255.
   int          m_state, m_gain, m_cnt, m_as, m_rs, m_sl;
   bit          m_valid, m_ovr;
   logic [15:0] m_data;
   int          ns_pulses;
   bit          verbose;
   logic [15:0] samples[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_gain = 0; m_cnt = 0;
      m_as = 0; m_rs = 0; m_sl = 0;
      m_valid = 0; m_ovr = 0; m_data = '0;
   endtask

   // One clock: predict from the current inputs, step the clock, compare registered outputs.
   task automatic cycle();
      bit live, free, ev, drop, acc;
      int p;
      #1;
      live = sample_tick && (m_state != 0) && !abort;
      free = !m_valid || out_ready;
      ev   = live && free;
      drop = live && !free;
      acc  = trig && !abort && (m_state == 0 || m_state == 3);
      chk("noise_step", {31'd0, noise_step}, {31'd0, ev});
      if (noise_step) ns_pulses++;
      if (ev) begin
         p = int'($signed(noise_in)) * m_gain;
         p = p >>> 8;
         m_data  = p[15:0];
         m_valid = 1;
      end else if (out_ready) begin
         m_valid = 0;
      end
      if (drop) m_ovr = 1;
      if (abort) begin
         m_state = 0;
         m_gain  = 0;
      end else if (acc) begin
         m_as = attack_step; m_rs = release_step; m_sl = sustain_len;
         if (m_state == 0) m_gain = 0;
         m_state = 1;
      end else if (ev) begin
         if (m_state == 1) begin
            if (m_as == 0 || m_gain + m_as >= 255) begin
               m_gain = 255; m_cnt = m_sl; m_state = 2;
            end else begin
               m_gain = m_gain + m_as;
            end
         end else if (m_state == 2) begin
            if (m_cnt == 0) m_state = 3;
            else m_cnt = m_cnt - 1;
         end else begin
            if (m_rs == 0 || m_gain - m_rs <= 0) begin
               m_gain = 0; m_state = 0;
            end else begin
               m_gain = m_gain - m_rs;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("state_o", {30'd0, state_o}, m_state);
      chk("busy", {31'd0, busy}, {31'd0, m_state != 0});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_data", {16'd0, out_data}, {16'd0, m_data});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (ev) begin
         samples.push_back(out_data);
         if (verbose) $display("sample: data=%h state=%0d gain=%0d", out_data, state_o, m_gain);
      end
   endtask

   task automatic tick();
      sample_tick = 1; cycle();
      sample_tick = 0; cycle();
   endtask

   task automatic do_trig(input int a, input int r, input int s);
      attack_step = 8'(a); release_step = 8'(r); sustain_len = 16'(s);
      trig = 1; cycle();
      trig = 0;
   endtask

   task automatic do_abort();
      abort = 1; cycle();
      abort = 0; cycle();
   endtask

   logic [15:0] ramp_exp[8];
   int          ns_before;

   initial begin
      ramp_exp = '{16'h0000, 16'h1000, 16'h2000, 16'h3000,
                   16'h3FC0, 16'h3FC0, 16'h3FC0, 16'h1FC0};
      verbose = 1;
      reset = 1; sample_tick = 0; trig = 0; abort = 0;
      attack_step = 0; release_step = 0; sustain_len = 0;
      noise_in = 16'h4000; out_ready = 1; ns_pulses = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {30'd0, state_o}, 0);
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_data", {16'd0, out_data}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_noise_step", {31'd0, noise_step}, 0);
      reset = 0;

      // Attack ramp through release.
      do_trig(64, 128, 1);
      ns_pulses = 0; samples.delete();
      for (int i = 0; i < 20 && m_state != 0; i++) tick();
      chk("ramp_count", samples.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < samples.size()) chk($sformatf("ramp_%0d", i), {16'd0, samples[i]}, {16'd0, ramp_exp[i]});
      end
      chk("ramp_pulses", ns_pulses, 8);
      chk("ramp_idle", {31'd0, busy}, 0);

      // Sign handling at gain 0 and full gain.
      noise_in = 16'h8000; samples.delete();
      do_trig(0, 0, 0);
      repeat (3) tick();
      chk("sign_g0", {16'd0, samples[0]}, 32'h0000);
      chk("sign_g255", {16'd0, samples[1]}, 32'h8080);
      noise_in = 16'h4000;

      // Backpressure: held slot, dropped ticks, overrun.
      do_trig(64, 128, 3);
      sample_tick = 1; cycle();
      sample_tick = 0; out_ready = 0; cycle();
      ns_before = ns_pulses;
      sample_tick = 1; cycle(); cycle();
      sample_tick = 0; cycle();
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_data", {16'd0, out_data}, 0);
      chk("bp_overrun", {31'd0, overrun}, 1);
      chk("bp_pulses", ns_pulses - ns_before, 0);
      out_ready = 1; cycle();
      chk("bp_drain", {31'd0, out_valid}, 0);
      samples.delete();
      tick();
      chk("bp_next", {16'd0, samples[0]}, 32'h1000);
      do_abort();

      // Abort in SUSTAIN with a pending sample; abort beats trig.
      do_trig(0, 0, 5);
      sample_tick = 1; out_ready = 0; cycle();
      sample_tick = 0; abort = 1; cycle();
      abort = 0;
      chk("abort_state", {30'd0, state_o}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_pending", {31'd0, out_valid}, 1);
      out_ready = 1; cycle();
      chk("abort_drained", {31'd0, out_valid}, 0);
      abort = 1; trig = 1; cycle();
      abort = 0; trig = 0; cycle();
      chk("abort_trig", {30'd0, state_o}, 0);

      // Retrigger in RELEASE keeps gain 127.
      do_trig(64, 128, 0);
      for (int i = 0; i < 20 && !(m_state == 3 && m_gain == 127); i++) tick();
      chk("retrig_pre", {30'd0, state_o}, 3);
      do_trig(64, 128, 0);
      chk("retrig_state", {30'd0, state_o}, 1);
      samples.delete();
      tick();
      chk("retrig_gain", {16'd0, samples[0]}, 32'h1FC0);
      do_abort();

      // Zero steps: full gain after one attack tick, idle after one release tick.
      do_trig(0, 0, 0);
      tick();
      chk("as0_state", {30'd0, state_o}, 2);
      tick();
      tick();
      chk("rs0_state", {30'd0, state_o}, 0);

      // Asynchronous reset mid-burst.
      do_trig(64, 128, 0);
      sample_tick = 1; out_ready = 0; cycle();
      sample_tick = 0;
      chk("arst_pre_valid", {31'd0, out_valid}, 1);
      #2 reset = 1;
      #1;
      chk("arst_state", {30'd0, state_o}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_valid", {31'd0, out_valid}, 0);
      chk("arst_data", {16'd0, out_data}, 0);
      chk("arst_overrun", {31'd0, overrun}, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 0; out_ready = 1;

      // Random traffic against the model.
      verbose = 0;
      for (int i = 0; i < 1500; i++) begin
         sample_tick  = ($urandom_range(0, 2) == 0);
         trig         = ($urandom_range(0, 15) == 0);
         abort        = ($urandom_range(0, 63) == 0);
         out_ready    = ($urandom_range(0, 3) != 0);
         noise_in     = 16'($urandom);
         attack_step  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         release_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         sustain_len  = 16'($urandom_range(0, 4));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
